// File: rtl/sonar_ranger.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : sonar_ranger
// | Brief    : HC-SR04 style trigger/echo ranging controller with echo-width
// |            capture; macro SONAR_AUTO_REPEAT_EN adds free-running 'auto' mode.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module sonar_ranger #(
    parameter int CNT_W           = 32,
    parameter int TRIG_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES  = 1900000,
    parameter int COOLDOWN_CYCLES = 3000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SONAR_AUTO_REPEAT_EN
    input  logic             auto,
`endif
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] width
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_COOLDOWN  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] C_TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);

    state_t             r_state, w_state_n;
    logic   [CNT_W-1:0] r_cnt, w_cnt_n, w_cnt_inc;
    logic   [CNT_W-1:0] r_width, w_width_n;
    logic               r_valid, w_valid_n;
    logic               r_timeout, w_timeout_n;
    logic               r_done, w_done_n;
    logic               r_e1, r_es, r_es_d;
    logic               w_rise, w_fall;
    logic               w_launch, w_rearm;

`ifdef SONAR_AUTO_REPEAT_EN
    assign w_launch = start | auto;
    assign w_rearm  = auto;
`else
    assign w_launch = start;
    assign w_rearm  = 1'b0;
`endif

    assign w_rise    = r_es & ~r_es_d;
    assign w_fall    = ~r_es & r_es_d;
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_width   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_e1      <= 1'b0;
            r_es      <= 1'b0;
            r_es_d    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_width   <= w_width_n;
            r_valid   <= w_valid_n;
            r_timeout <= w_timeout_n;
            r_done    <= w_done_n;
            r_e1      <= echo;
            r_es      <= r_e1;
            r_es_d    <= r_es;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_width_n   = r_width;
        w_valid_n   = r_valid;
        w_timeout_n = r_timeout;
        w_done_n    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_n = S_TRIG;
                    w_cnt_n   = '0;
                end
            end
            S_TRIG: begin
                if (r_cnt >= C_TRIG_LAST) begin
                    w_state_n = S_WAIT_RISE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            S_WAIT_RISE: begin
                // The counter holds completed wait cycles, so the last allowed
                // cycle is TIMEOUT-1 and done lands TIMEOUT cycles after entry.
                if (w_rise) begin
                    w_state_n = S_MEASURE;
                    w_cnt_n   = C_ONE;
                end else if (r_cnt >= C_TIMEOUT_LAST) begin
                    w_state_n   = S_COOLDOWN;
                    w_cnt_n     = '0;
                    w_width_n   = C_TIMEOUT;
                    w_valid_n   = 1'b0;
                    w_timeout_n = 1'b1;
                    w_done_n    = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            S_MEASURE: begin
                if (w_fall) begin
                    w_state_n   = S_COOLDOWN;
                    w_cnt_n     = '0;
                    w_width_n   = r_cnt;
                    w_valid_n   = 1'b1;
                    w_timeout_n = 1'b0;
                    w_done_n    = 1'b1;
                end else if (r_cnt >= C_TIMEOUT) begin
                    w_state_n   = S_COOLDOWN;
                    w_cnt_n     = '0;
                    w_width_n   = C_TIMEOUT;
                    w_valid_n   = 1'b0;
                    w_timeout_n = 1'b1;
                    w_done_n    = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            S_COOLDOWN: begin
                if (r_cnt >= C_COOL_LAST) begin
                    w_state_n = w_rearm ? S_TRIG : S_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign trig    = (r_state == S_TRIG);
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign valid   = r_valid;
    assign timeout = r_timeout;
    assign width   = r_width;

endmodule
`default_nettype wire

// File: tb/tb_sonar_ranger.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : tb_sonar_ranger
// | Brief    : Self-checking bench for sonar_ranger (vector table + random model).
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module tb_sonar_ranger;

    localparam int CNT_W    = 32;
    localparam int TRIG     = 4;
    localparam int TMO      = 64;
    localparam int COOL     = 8;
    localparam int SYNC_LAT = 2;
    localparam int NEVER    = 100000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             echo = 1'b0;
`ifdef SONAR_AUTO_REPEAT_EN
    logic             auto = 1'b0;
`endif
    logic             trig, busy, done, valid, timeout;
    logic [CNT_W-1:0] width;

    int n_tests = 0;
    int n_fail  = 0;

    sonar_ranger #(
        .CNT_W(CNT_W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef SONAR_AUTO_REPEAT_EN
        .auto(auto),
`endif
        .echo(echo), .trig(trig), .busy(busy), .done(done),
        .valid(valid), .timeout(timeout), .width(width)
    );

    always #5 clk = ~clk;

    // pre/drop: echo held high from before start until cycle 'drop' of the wait.
    // d/h: echo pulse starting 'd' cycles after trig falls, lasting 'h' cycles.
    typedef struct {
        logic pre;
        int   drop;
        int   d;
        int   h;
        bit   glitch;
        logic e_valid;
        logic e_tmo;
        int   e_width;
        int   e_done;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic echo_at(input vec_t v, input int j);
        return ((j >= v.d) && (j < v.d + v.h)) || (v.pre && (j < v.drop));
    endfunction

    // Outcome from the rules: a rise is seen SYNC_LAT cycles after it is driven
    // and must land inside the TMO-cycle wait window; a high longer than TMO
    // times out one cycle after the count reaches TMO.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        int   seen = v.d + SYNC_LAT;
        if (v.h == 0 || seen >= TMO) begin
            r.e_valid = 1'b0; r.e_tmo = 1'b1; r.e_width = TMO; r.e_done = TMO;
        end else if (v.h <= TMO) begin
            r.e_valid = 1'b1; r.e_tmo = 1'b0; r.e_width = v.h; r.e_done = v.d + v.h + 3;
        end else begin
            r.e_valid = 1'b0; r.e_tmo = 1'b1; r.e_width = TMO; r.e_done = seen + TMO + 1;
        end
        return r;
    endfunction

    // Called at a negedge with the DUT idle.
    task automatic measure(input string tag, input vec_t v);
        int     trig_hi = 0;
        int     done_at = -1;
        int     pulses = 0;
        int     retrig = 0;
        longint busy7 = -1, busy8 = -1, w_s = -1, v_s = -1, t_s = -1;
        echo  = v.pre;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        for (int k = 0; k < 50 && trig === 1'b1; k++) begin
            trig_hi++;
            @(negedge clk);
        end
        check({tag, "_trig_len"}, trig_hi, TRIG);
        for (int j = 0; j < 300; j++) begin
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = j;
            end
            if (trig === 1'b1) retrig++;
            if (done_at >= 0 && j == done_at + COOL - 1) busy7 = busy;
            if (done_at >= 0 && j == done_at + COOL) begin
                busy8 = busy; w_s = width; v_s = valid; t_s = timeout;
                break;
            end
            echo = echo_at(v, j);
            if (v.glitch && done_at >= 0 && j >= done_at + 2 && j <= done_at + 4) echo = 1'b1;
            start = v.glitch && ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        echo  = 1'b0;
        check({tag, "_done_at"}, done_at, v.e_done);
        check({tag, "_done_pulses"}, pulses, 1);
        check({tag, "_retrig"}, retrig, 0);
        check({tag, "_width"}, w_s, v.e_width);
        check({tag, "_valid"}, v_s, v.e_valid);
        check({tag, "_timeout"}, t_s, v.e_tmo);
        check({tag, "_busy_cool"}, busy7, 1);
        check({tag, "_busy_fall"}, busy8, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t rv;
        int   rises[3];
        int   nr;
        logic prev;

        //             pre  drop   d   h  gl  valid tmo  width done
        tbl[0] = '{1'b0, 0,     5, 20, 1'b0, 1'b1, 1'b0, 20, 28};
        tbl[1] = '{1'b0, 0,     0,  0, 1'b0, 1'b0, 1'b1, 64, 64};
        tbl[2] = '{1'b1, NEVER, 0,  0, 1'b0, 1'b0, 1'b1, 64, 64};
        tbl[3] = '{1'b1, 2,     6, 10, 1'b0, 1'b1, 1'b0, 10, 19};
        tbl[4] = '{1'b0, 0,    61,  1, 1'b0, 1'b1, 1'b0,  1, 65};
        tbl[5] = '{1'b0, 0,    62,  3, 1'b0, 1'b0, 1'b1, 64, 64};
        tbl[6] = '{1'b0, 0,     0, 64, 1'b0, 1'b1, 1'b0, 64, 67};
        tbl[7] = '{1'b0, 0,     0, 65, 1'b0, 1'b0, 1'b1, 64, 67};
        tbl[8] = '{1'b0, 0,     0,  1, 1'b1, 1'b1, 1'b0,  1,  4};

        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_width", width, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) measure($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 12; i++) begin
            rv.pre = 1'($urandom_range(0, 1));
            if (rv.pre) begin
                rv.drop = $urandom_range(0, 10);
                rv.d    = rv.drop + 1 + $urandom_range(0, 58);
            end else begin
                rv.drop = 0;
                rv.d    = $urandom_range(0, 70);
            end
            rv.h      = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80);
            rv.glitch = 1'b1;
            measure($sformatf("rnd%0d", i), ref_model(rv));
        end

        // Reset in the middle of a measurement
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && trig === 1'b1; k++) @(negedge clk);
        echo = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_trig", trig, 0);
        check("midrst_busy", busy, 0);
        check("midrst_width", width, 0);
        check("midrst_valid", valid, 0);
        reset = 1'b0;
        echo  = 1'b0;
        repeat (3) @(negedge clk);

`ifdef SONAR_AUTO_REPEAT_EN
        auto = 1'b1;
        @(negedge clk);
        check("auto_launch", trig, 1);
        nr = 1;
        rises[0] = 0;
        prev = 1'b1;
        for (int j = 1; j < 400; j++) begin
            @(negedge clk);
            if (trig === 1'b1 && prev === 1'b0 && nr < 3) begin
                rises[nr] = j;
                nr++;
                if (nr == 3) auto = 1'b0;
            end
            if (nr == 3 && j == rises[2] + TRIG + TMO + COOL - 1) check("auto_busy_last", busy, 1);
            if (nr == 3 && j == rises[2] + TRIG + TMO + COOL) begin
                check("auto_idle", busy, 0);
                break;
            end
            prev = trig;
        end
        check("auto_rises", nr, 3);
        check("auto_gap1", rises[1] - rises[0], TRIG + TMO + COOL);
        check("auto_gap2", rises[2] - rises[1], TRIG + TMO + COOL);
        auto = 1'b0;
        repeat (20) @(negedge clk);
        check("auto_stays_idle", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
